// File: rtl/fifo_pkg.sv
// Shared types, defaults and elaboration helpers for the single-clock FIFO.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SIZE  = 16;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_regfile
    import fifo_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SIZE    = DEF_SIZE,
    parameter int PTR_LEN = $clog2(SIZE)
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [PTR_LEN-1:0] i_waddr,
    input  logic [WIDTH-1:0]   i_wdata,
    input  logic [PTR_LEN-1:0] i_raddr,
    output logic [WIDTH-1:0]   o_rdata
);

    logic [WIDTH-1:0] r_mem [SIZE];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags, flush, sticky errors
// and a choice of registered-read or first-word-fall-through output.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SIZE       = DEF_SIZE,
    parameter int PTR_LEN    = $clog2(SIZE),
    parameter int FWFT       = 1,
    parameter int AFULL_THR  = SIZE - 2,
    parameter int AEMPTY_THR = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             flush,
    input  logic             err_clr,
    input  logic             w_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             r_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [PTR_LEN:0] count,
    output logic             overflow,
    output logic             underflow
);

    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam int CW = PTR_LEN + 1;
    localparam logic [CW-1:0] C_SIZE = CW'(SIZE);
    localparam logic [CW-1:0] C_AF   = CW'(AFULL_THR);
    localparam logic [CW-1:0] C_AE   = CW'(AEMPTY_THR);

    if (!is_pow2(SIZE) || SIZE < 2) begin : g_bad_size
        $error("sync_fifo: SIZE=%0d must be a power of 2 and >= 2", SIZE);
    end
    if (AFULL_THR < 1 || AFULL_THR > SIZE) begin : g_bad_afull
        $error("sync_fifo: AFULL_THR=%0d out of range 1..SIZE", AFULL_THR);
    end
    if (AEMPTY_THR < 0 || AEMPTY_THR > SIZE - 1) begin : g_bad_aempty
        $error("sync_fifo: AEMPTY_THR=%0d out of range 0..SIZE-1", AEMPTY_THR);
    end

    logic [CW-1:0]    r_wr_ptr, r_rd_ptr, r_count, w_count_next;
    logic             r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;
    logic             w_wr_acc, w_rd_acc, w_ovf_set, w_unf_set;
    logic [WIDTH-1:0] w_rd_data;

    // flush swallows both requests, so it can neither move data nor raise errors
    assign w_wr_acc  = w_en & ~r_full  & ~flush;
    assign w_rd_acc  = r_en & ~r_empty & ~flush;
    assign w_ovf_set = w_en &  r_full  & ~flush;
    assign w_unf_set = r_en &  r_empty & ~flush;

    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = '0;
        end else begin
            w_count_next = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count  <= w_count_next;
            r_full   <= (w_count_next == C_SIZE);
            r_empty  <= (w_count_next == '0);
            r_afull  <= (w_count_next >= C_AF);
            r_aempty <= (w_count_next <= C_AE);
        end
    end

    // A new error in the same cycle as err_clr wins over the clear.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_set)    r_ovf <= 1'b1;
            else if (err_clr) r_ovf <= 1'b0;
            if (w_unf_set)    r_unf <= 1'b1;
            else if (err_clr) r_unf <= 1'b0;
        end
    end

    fifo_regfile #(
        .WIDTH   (WIDTH),
        .SIZE    (SIZE),
        .PTR_LEN (PTR_LEN)
    ) u_regfile (
        .i_clk   (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[PTR_LEN-1:0]),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr[PTR_LEN-1:0]),
        .o_rdata (w_rd_data)
    );

    // Output handshake: in FWFT mode data_valid means "head word on data_out",
    // and r_en high in a cycle where data_valid is high pops it at the edge.
    // In standard mode r_en requests a word; data_valid pulses for one cycle
    // with that word on data_out the cycle after the accepted request.
    if (MODE == FIFO_FWFT) begin : g_fwft
        // Empty storage is stale, so present zero rather than an old word.
        assign data_out   = r_empty ? '0 : w_rd_data;
        assign data_valid = ~r_empty;
    end else begin : g_std
        logic [WIDTH-1:0] r_dout;
        logic             r_dvalid;

        always_ff @(posedge clk) begin
            if (srst) begin
                r_dout   <= '0;
                r_dvalid <= 1'b0;
            end else begin
                r_dvalid <= w_rd_acc;
                if (w_rd_acc) r_dout <= w_rd_data;
            end
        end

        assign data_out   = r_dout;
        assign data_valid = r_dvalid;
    end

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule
